// File: rtl/parammod_evt_pkg.sv
// Shared types and constants for the pulse event arbiter slice.
package parammod_evt_pkg;

  typedef enum logic [1:0] {EVT_IDLE, EVT_OFFER, EVT_GAP} evt_state_e;

  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} act_e;

  localparam int GAP_W = 8;

  // (base + off) mod n for base < n and off < n, without a divider.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/oneshot.sv
// One-cycle pulse on the transition of a synchronised level into its active value.
module oneshot
  import parammod_evt_pkg::*;
#(
  parameter act_e ACT = HIGH
) (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic pulse
);

  logic was_act;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) was_act <= 1'b0;
    else       was_act <= (level_in == ACT);
  end

  assign pulse = (level_in == ACT) && !was_act;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_pick
  import parammod_evt_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    any = |req;
    idx = '0;
    // Scan farthest-first so the nearest request at or after ptr overwrites the rest.
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_idx(int'(ptr), k, N)]) idx = IDW'(wrap_idx(int'(ptr), k, N));
    end
  end

endmodule

// File: rtl/pulse_event_arb.sv
// Per-channel edge capture, pending/overflow tracking and round-robin issue of
// one event at a time on a valid/ready port with an idle gap after each accept.
module pulse_event_arb
  import parammod_evt_pkg::*;
#(
  parameter  int   N   = 4,
  parameter  act_e ACT = HIGH,
  parameter  int   GAP = 2,
  localparam int   IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   level_in,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  input  logic           evt_ready,
  output logic [N-1:0]   pend_out,
  output logic [N-1:0]   ovf_out,
  input  logic           clr_ovf
);

  evt_state_e       state;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [N-1:0]     pulse;
  logic [N-1:0]     accept;

  for (genvar i = 0; i < N; i++) begin : g_edge
    oneshot #(.ACT(ACT)) u_oneshot (
      .clk      (clk),
      .reset    (reset),
      .level_in (level_in[i]),
      .pulse    (pulse[i])
    );
  end

  rr_pick #(.N(N)) u_pick (
    .req (pend_out),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    accept = '0;
    if (evt_valid && evt_ready) accept[evt_id] = 1'b1;
  end

  // A pulse on the channel being accepted re-arms it instead of counting as overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_out <= '0;
      ovf_out  <= '0;
    end else begin
      pend_out <= pulse | (pend_out & ~accept);
      ovf_out  <= (pulse & pend_out & ~accept) | (ovf_out & ~{N{clr_ovf}});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EVT_IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      ptr       <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        EVT_IDLE: begin
          if (pick_any) begin
            evt_id    <= pick_idx;
            evt_valid <= 1'b1;
            state     <= EVT_OFFER;
          end
        end
        EVT_OFFER: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            ptr       <= (evt_id == IDW'(N - 1)) ? '0 : evt_id + IDW'(1);
            if (GAP > 0) begin
              gap_cnt <= GAP_W'(GAP);
              state   <= EVT_GAP;
            end else begin
              state   <= EVT_IDLE;
            end
          end
        end
        EVT_GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) state <= EVT_IDLE;
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= EVT_IDLE;
        end
      endcase
    end
  end

endmodule
